uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter between NUM_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity. A grant is held until the requester's last byte, the burst limit, or the requester dropping req.
- Sequences the transmitter through a start/busy/done handshake and returns a per-byte ack to the granted requester.
- Sits between the on-chip producers (status, debug, echo) and the FPGA-to-PC UART transmitter.

---
 rtl/uart_arb_pkg.sv | 29 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding,
// byte width, the stream-tag nibble and a one-hot decode helper.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    // High nibble of the stream-tag byte that PC-side software demultiplexes on.
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_TAG  = 2'd3
    } arb_state_t;

    // Index of the set bit in a one-hot vector (zero for an all-zero vector).
    function automatic int onehotToIdx(input logic [15:0] oneHot);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (oneHot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: finds the first requester above the pointer,
// wrapping modulo NUM_REQ, so the previous owner ends up lowest priority.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rrPtr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_anyReq
);

    // Scan upward from rrPtr+1 and keep only the first hit.
    always_comb begin
        logic             found;
        int               pos;
        logic [PTR_W-1:0] w_idx;
        o_winner = '0;
        o_anyReq = |i_req;
        found    = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            pos   = (int'(i_rrPtr) + off) % NUM_REQ;
            w_idx = PTR_W'(pos);
            if (!found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte transmitter
// between NUM_REQ byte-stream producers. A grant lasts until the owner's
// last byte, MAX_BURST bytes, or the owner dropping req.
// Optional macro UART_ARB_TAG_EN: emit a stream-tag byte {A, owner}
// at the start of every grant so the PC can demultiplex the streams.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      active
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t          r_state,   w_state;
    logic [NUM_REQ-1:0]  r_grant,   w_grant;
    logic [PTR_W-1:0]    r_idx,     w_idx;
    logic [PTR_W-1:0]    r_rrPtr,   w_rrPtr;
    logic [BURST_W-1:0]  r_burst,   w_burst;
    logic                r_last,    w_last;
    logic                r_txStart, w_txStart;
    logic [NUM_REQ-1:0]  r_reqAck,  w_reqAck;
    logic [BYTE_W-1:0]   r_txData,  w_txData;
`ifdef UART_ARB_TAG_EN
    logic                r_tagSent, w_tagSent;
`endif

    logic [NUM_REQ-1:0]  w_winner;
    logic                w_anyReq;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req    (req),
        .i_rrPtr  (r_rrPtr),
        .o_winner (w_winner),
        .o_anyReq (w_anyReq)
    );

    // State and output registers; reset aborts any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_rrPtr   <= PTR_W'(NUM_REQ - 1);
            r_burst   <= '0;
            r_last    <= 1'b0;
            r_txStart <= 1'b0;
            r_reqAck  <= '0;
            r_txData  <= '0;
`ifdef UART_ARB_TAG_EN
            r_tagSent <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_idx     <= w_idx;
            r_rrPtr   <= w_rrPtr;
            r_burst   <= w_burst;
            r_last    <= w_last;
            r_txStart <= w_txStart;
            r_reqAck  <= w_reqAck;
            r_txData  <= w_txData;
`ifdef UART_ARB_TAG_EN
            r_tagSent <= w_tagSent;
`endif
        end
    end

    // Next-state logic: grant, issue one byte per SEND, decide release at tx_done.
    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_idx     = r_idx;
        w_rrPtr   = r_rrPtr;
        w_burst   = r_burst;
        w_last    = r_last;
        w_txStart = 1'b0;
        w_reqAck  = '0;
        w_txData  = r_txData;
`ifdef UART_ARB_TAG_EN
        w_tagSent = r_tagSent;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_grant = w_winner;
                    w_idx   = PTR_W'(onehotToIdx(16'(w_winner)));
                    w_burst = '0;
`ifdef UART_ARB_TAG_EN
                    w_state = ST_TAG;
`else
                    w_state = ST_SEND;
`endif
                end
            end
            ST_SEND: begin
                if (!req[r_idx]) begin
                    w_grant = '0;
                    w_rrPtr = r_idx;
                    w_state = ST_IDLE;
                end else if (!tx_busy) begin
                    w_txStart       = 1'b1;
                    w_reqAck[r_idx] = 1'b1;
                    w_txData        = req_data[int'(r_idx)*BYTE_W +: BYTE_W];
                    w_last          = req_last[r_idx];
                    w_burst         = r_burst + BURST_W'(1);
                    w_state         = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (r_last || (r_burst == BURST_W'(MAX_BURST)) || !req[r_idx]) begin
                        w_grant = '0;
                        w_rrPtr = r_idx;
                        w_state = ST_IDLE;
                    end else begin
                        w_state = ST_SEND;
                    end
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                if (!r_tagSent) begin
                    if (!tx_busy) begin
                        w_txStart = 1'b1;
                        w_txData  = {TAG_NIBBLE, 4'(r_idx)};
                        w_tagSent = 1'b1;
                    end
                end else if (tx_done) begin
                    w_tagSent = 1'b0;
                    w_state   = ST_SEND;
                end
            end
`endif
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign grant    = r_grant;
    assign req_ack  = r_reqAck;
    assign tx_start = r_txStart;
    assign tx_data  = r_txData;
    assign active   = |r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4) with scripted
// requester streams, a simple transmitter model and an expected-frame queue.
// Build with UART_ARB_TAG_EN defined to expect the stream-tag bytes.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX_BURST = 4;
    localparam int TX_LEN = 10;
    localparam int MAXB = 32;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] ack;
        logic [3:0] grant;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done = 1'b0;
    logic        active;

    logic        stallBusy = 1'b0;
    logic        mBusy = 1'b0;
    int          mCnt = 0;

    logic [7:0]  streamByte [4][MAXB];
    logic        streamLast [4][MAXB];
    int          streamLen [4] = '{default: 0};
    int          pos [4] = '{default: 0};
    int          ackCnt [4] = '{default: 0};

    logic [7:0]  obsData [256];
    logic [3:0]  obsAck [256];
    logic [3:0]  obsGrant [256];
    int          obsCnt = 0;
    int          rdIdx = 0;

    exp_t        expQ [$];
    int          compared = 0;
    int          mismatched = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .active   (active)
    );

    always #5 clk = ~clk;

    assign tx_busy = mBusy | stallBusy;

    // Requesters present the byte at their stream position while any remain.
    always_comb begin
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pos[r] < streamLen[r]) begin
                req[r]            = 1'b1;
                req_data[r*8 +: 8] = streamByte[r][pos[r]];
                req_last[r]       = streamLast[r][pos[r]];
            end
        end
    end

    // Each requester advances to its next byte after seeing its ack.
    always @(negedge clk) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ack[r]) begin
                pos[r]    <= pos[r] + 1;
                ackCnt[r] <= ackCnt[r] + 1;
            end
        end
    end

    // Transmitter model: busy for TX_LEN cycles after tx_start, then a tx_done pulse.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (tx_start) begin
            mBusy <= 1'b1;
            mCnt  <= TX_LEN - 1;
        end else if (mBusy) begin
            if (mCnt == 0) begin
                mBusy   <= 1'b0;
                tx_done <= 1'b1;
            end else begin
                mCnt <= mCnt - 1;
            end
        end
    end

    // Record every frame the arbiter starts, with the ack and grant beside it.
    always @(negedge clk) begin
        if (tx_start) begin
            obsData[obsCnt]  <= tx_data;
            obsAck[obsCnt]   <= req_ack;
            obsGrant[obsCnt] <= grant;
            obsCnt           <= obsCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] d, input logic last);
        streamByte[r][streamLen[r]] = d;
        streamLast[r][streamLen[r]] = last;
        streamLen[r] = streamLen[r] + 1;
    endtask

    task automatic expByte(input int r, input logic [7:0] d);
        exp_t e;
        e.data  = d;
        e.ack   = 4'(1 << r);
        e.grant = 4'(1 << r);
        expQ.push_back(e);
    endtask

    task automatic expGrant(input int r);
`ifdef UART_ARB_TAG_EN
        exp_t e;
        e.data  = 8'hA0 | 8'(r);
        e.ack   = 4'h0;
        e.grant = 4'(1 << r);
        expQ.push_back(e);
`else
        if (r < 0) $display("[TB] bad requester index");
`endif
    endtask

    task automatic drainExpected(input int budget);
        exp_t e;
        int cycles;
        cycles = 0;
        while (expQ.size() > 0 && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
            while (rdIdx < obsCnt && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("txData#%0d", rdIdx), 32'(obsData[rdIdx]), 32'(e.data));
                checkOutput($sformatf("ack#%0d", rdIdx), 32'(obsAck[rdIdx]), 32'(e.ack));
                checkOutput($sformatf("grant#%0d", rdIdx), 32'(obsGrant[rdIdx]), 32'(e.grant));
                rdIdx++;
            end
        end
        if (expQ.size() > 0) begin
            checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    task automatic waitIdle(input int budget);
        int cycles;
        cycles = 0;
        while (active !== 1'b0 && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("idleReached", 32'(active), 32'd0);
    endtask

    task automatic waitForObs(input int target, input int budget);
        int cycles;
        cycles = 0;
        while (obsCnt < target && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (obsCnt < target) checkOutput("obsTimeout", 32'(obsCnt), 32'(target));
    endtask

    initial begin
        int s0;
        int a0;
`ifdef UART_ARB_TAG_EN
        int tagExtra = 1;
`else
        int tagExtra = 0;
`endif

        // Reset values
        #2;
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstActive", 32'(active), 32'd0);
        checkOutput("rstTxStart", 32'(tx_start), 32'd0);
        checkOutput("rstTxData", 32'(tx_data), 32'd0);
        checkOutput("rstAck", 32'(req_ack), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Fairness: all four single-byte packets, requester 0 has a second one
        $display("[TB] fairness");
        expGrant(0); expByte(0, 8'h40);
        expGrant(1); expByte(1, 8'h41);
        expGrant(2); expByte(2, 8'h42);
        expGrant(3); expByte(3, 8'h43);
        expGrant(0); expByte(0, 8'h44);
        @(negedge clk);
        applyStimulus(0, 8'h40, 1'b1);
        applyStimulus(0, 8'h44, 1'b1);
        applyStimulus(1, 8'h41, 1'b1);
        applyStimulus(2, 8'h42, 1'b1);
        applyStimulus(3, 8'h43, 1'b1);
        drainExpected(400);
        waitIdle(50);

        // Single requester, three-byte packet
        $display("[TB] single requester");
        a0 = ackCnt[0];
        expGrant(0); expByte(0, 8'h11); expByte(0, 8'h22); expByte(0, 8'h33);
        @(negedge clk);
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        drainExpected(300);
        checkOutput("singleHeld", 32'(grant), 32'h1);
        waitIdle(50);
        checkOutput("singleReleased", 32'(grant), 32'd0);
        checkOutput("singleAcks", 32'(ackCnt[0] - a0), 32'd3);

        // Burst limit: requester 1 streams ten bytes, requester 2 joins
        $display("[TB] burst limit");
        expGrant(1); expByte(1, 8'h60); expByte(1, 8'h61); expByte(1, 8'h62); expByte(1, 8'h63);
        expGrant(2); expByte(2, 8'h70); expByte(2, 8'h71);
        expGrant(1); expByte(1, 8'h64); expByte(1, 8'h65); expByte(1, 8'h66); expByte(1, 8'h67);
        expGrant(1); expByte(1, 8'h68); expByte(1, 8'h69);
        s0 = obsCnt;
        @(negedge clk);
        for (int k = 0; k < 10; k++) applyStimulus(1, 8'(8'h60 + k), 1'b0);
        waitForObs(s0 + 1, 100);
        applyStimulus(2, 8'h70, 1'b0);
        applyStimulus(2, 8'h71, 1'b1);
        drainExpected(800);
        waitIdle(50);

        // Busy stall while a grant is pending
        $display("[TB] busy stall");
        stallBusy = 1'b1;
        s0 = obsCnt;
        a0 = ackCnt[3];
        applyStimulus(3, 8'h5C, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("stallNoStart", 32'(obsCnt), 32'(s0));
        checkOutput("stallNoAck", 32'(ackCnt[3]), 32'(a0));
        checkOutput("stallGrant", 32'(grant), 32'h8);
        stallBusy = 1'b0;
        expGrant(3); expByte(3, 8'h5C);
        drainExpected(200);
        waitIdle(50);
        checkOutput("stallStarts", 32'(obsCnt - s0), 32'(1 + tagExtra));
        checkOutput("stallAcks", 32'(ackCnt[3] - a0), 32'd1);

        // Reset while waiting on a frame
        $display("[TB] reset mid-packet");
        expGrant(2); expByte(2, 8'h81);
        @(negedge clk);
        applyStimulus(2, 8'h81, 1'b0);
        applyStimulus(2, 8'h82, 1'b1);
        drainExpected(200);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRstGrant", 32'(grant), 32'd0);
        checkOutput("midRstActive", 32'(active), 32'd0);
        checkOutput("midRstTxStart", 32'(tx_start), 32'd0);
        checkOutput("midRstAck", 32'(req_ack), 32'd0);
        checkOutput("midRstTxData", 32'(tx_data), 32'd0);
        applyStimulus(0, 8'h90, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        expGrant(0); expByte(0, 8'h90);
        expGrant(2); expByte(2, 8'h82);
        drainExpected(400);
        waitIdle(50);

        // Requester 3 single byte (tag byte precedes it when tagging is built in)
        $display("[TB] tagged byte");
        s0 = obsCnt;
        a0 = ackCnt[3];
        expGrant(3); expByte(3, 8'h5A);
        @(negedge clk);
        applyStimulus(3, 8'h5A, 1'b1);
        drainExpected(200);
        waitIdle(50);
        checkOutput("tagFrames", 32'(obsCnt - s0), 32'(1 + tagExtra));
        checkOutput("tagAcks", 32'(ackCnt[3] - a0), 32'd1);

        checkOutput("noExtraFrames", 32'(obsCnt), 32'(rdIdx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
